// File: rtl/axis_seq_divider.sv
// axis_seq_divider: iterative radix-2 restoring divider with AXI-stream ports.
// Dividend and divisor arrive on independent slave channels in any order.
// Quotient and remainder leave on one master channel: {quotient, remainder}.
// A fixed WIDTH-cycle iteration is used for every operand pair, so divide by
// zero and the signed overflow case take the same time as ordinary divisions.

module axis_seq_divider #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_axis_dividend_tvalid,
    output logic                 s_axis_dividend_tready,
    input  logic [WIDTH-1:0]     s_axis_dividend_tdata,
    input  logic                 s_axis_divisor_tvalid,
    output logic                 s_axis_divisor_tready,
    input  logic [WIDTH-1:0]     s_axis_divisor_tdata,
    output logic                 m_axis_dout_tvalid,
    input  logic                 m_axis_dout_tready,
    output logic [2*WIDTH-1:0]   m_axis_dout_tdata,
    output logic                 m_axis_dout_tuser
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Operand capture: each channel has its own held flag and data buffer.
    logic               dividend_held_q, dividend_held_d;
    logic               divisor_held_q,  divisor_held_d;
    logic [WIDTH-1:0]   dividend_buf_q,  dividend_buf_d;
    logic [WIDTH-1:0]   divisor_buf_q,   divisor_buf_d;

    // Working registers of the restoring iteration.
    // rem_q keeps the partial remainder between steps; the shifted remainder
    // compared against the divisor is WIDTH+1 bits (rem_shift).
    logic [WIDTH-1:0]   rem_q,           rem_d;
    logic [WIDTH-1:0]   quo_q,           quo_d;
    logic [WIDTH-1:0]   div_mag_q,       div_mag_d;
    logic [WIDTH-1:0]   dividend_orig_q, dividend_orig_d;
    logic               neg_quot_q,      neg_quot_d;
    logic               neg_rem_q,       neg_rem_d;
    logic               div_zero_q,      div_zero_d;
    logic [CW-1:0]      count_q,         count_d;

    // Registered stream outputs.
    logic               dividend_tready_q, dividend_tready_d;
    logic               divisor_tready_q,  divisor_tready_d;
    logic               dout_tvalid_q,     dout_tvalid_d;
    logic [2*WIDTH-1:0] dout_tdata_q,      dout_tdata_d;
    logic               dout_tuser_q,      dout_tuser_d;

    // Handshake and control decodes.
    logic               dividend_fire;
    logic               divisor_fire;
    logic               start;
    logic               out_fire;
    logic [WIDTH-1:0]   dividend_now;
    logic [WIDTH-1:0]   divisor_now;

    // One restoring step and the final sign fix-up.
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     rem_diff;
    logic               step_ge;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic [WIDTH-1:0]   quot_result;
    logic [WIDTH-1:0]   rem_result;

    // Absolute value in signed mode; the most negative value maps onto
    // itself, which is the correct unsigned magnitude 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (SIGNED && v[WIDTH-1]) begin
            return -v;
        end
        return v;
    endfunction

    assign dividend_fire = s_axis_dividend_tvalid & dividend_tready_q;
    assign divisor_fire  = s_axis_divisor_tvalid  & divisor_tready_q;
    assign start         = (state_q == IDLE)
                         & (dividend_held_q | dividend_fire)
                         & (divisor_held_q  | divisor_fire);
    assign out_fire      = dout_tvalid_q & m_axis_dout_tready;
    assign dividend_now  = dividend_held_q ? dividend_buf_q : s_axis_dividend_tdata;
    assign divisor_now   = divisor_held_q  ? divisor_buf_q  : s_axis_divisor_tdata;

    // State register: reset drops any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: start once both operands are present, run WIDTH steps,
    // then wait for the consumer to take the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)                state_d = CALC;
            CALC:    if (count_q == LAST_ITER) state_d = DONE;
            DONE:    if (out_fire)             state_d = IDLE;
            default:                           state_d = IDLE;
        endcase
    end

    // One restoring step on magnitudes plus the sign/zero fix-up of the final step.
    always_comb begin
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, div_mag_q};
        step_ge   = (rem_shift >= {1'b0, div_mag_q});
        rem_step  = step_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        quo_step  = {quo_q[WIDTH-2:0], step_ge};
        if (div_zero_q) begin
            quot_result = '1;
            rem_result  = dividend_orig_q;
        end else begin
            quot_result = neg_quot_q ? -quo_step : quo_step;
            rem_result  = neg_rem_q  ? -rem_step : rem_step;
        end
    end

    // Outputs and datapath: operand capture, iteration, result hold/release.
    always_comb begin
        dividend_held_d = dividend_held_q;
        divisor_held_d  = divisor_held_q;
        dividend_buf_d  = dividend_buf_q;
        divisor_buf_d   = divisor_buf_q;
        rem_d           = rem_q;
        quo_d           = quo_q;
        div_mag_d       = div_mag_q;
        dividend_orig_d = dividend_orig_q;
        neg_quot_d      = neg_quot_q;
        neg_rem_d       = neg_rem_q;
        div_zero_d      = div_zero_q;
        count_d         = count_q;
        dout_tvalid_d   = dout_tvalid_q;
        dout_tdata_d    = dout_tdata_q;
        dout_tuser_d    = dout_tuser_q;

        case (state_q)
            IDLE: begin
                if (dividend_fire) begin
                    dividend_held_d = 1'b1;
                    dividend_buf_d  = s_axis_dividend_tdata;
                end
                if (divisor_fire) begin
                    divisor_held_d = 1'b1;
                    divisor_buf_d  = s_axis_divisor_tdata;
                end
                if (start) begin
                    rem_d           = '0;
                    quo_d           = magnitude(dividend_now);
                    div_mag_d       = magnitude(divisor_now);
                    dividend_orig_d = dividend_now;
                    neg_quot_d      = SIGNED & (dividend_now[WIDTH-1] ^ divisor_now[WIDTH-1]);
                    neg_rem_d       = SIGNED & dividend_now[WIDTH-1];
                    div_zero_d      = (divisor_now == '0);
                    count_d         = '0;
                end
            end
            CALC: begin
                rem_d   = rem_step;
                quo_d   = quo_step;
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    dout_tvalid_d = 1'b1;
                    dout_tdata_d  = {quot_result, rem_result};
                    dout_tuser_d  = div_zero_q;
                end
            end
            DONE: begin
                if (out_fire) begin
                    dout_tvalid_d   = 1'b0;
                    dividend_held_d = 1'b0;
                    divisor_held_d  = 1'b0;
                end
            end
            default: begin
                dout_tvalid_d = 1'b0;
            end
        endcase

        dividend_tready_d = (state_d == IDLE) & ~dividend_held_d;
        divisor_tready_d  = (state_d == IDLE) & ~divisor_held_d;
    end

    // Datapath and output registers; readies come up high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dividend_held_q   <= 1'b0;
            divisor_held_q    <= 1'b0;
            dividend_buf_q    <= '0;
            divisor_buf_q     <= '0;
            rem_q             <= '0;
            quo_q             <= '0;
            div_mag_q         <= '0;
            dividend_orig_q   <= '0;
            neg_quot_q        <= 1'b0;
            neg_rem_q         <= 1'b0;
            div_zero_q        <= 1'b0;
            count_q           <= '0;
            dividend_tready_q <= 1'b1;
            divisor_tready_q  <= 1'b1;
            dout_tvalid_q     <= 1'b0;
            dout_tdata_q      <= '0;
            dout_tuser_q      <= 1'b0;
        end else begin
            dividend_held_q   <= dividend_held_d;
            divisor_held_q    <= divisor_held_d;
            dividend_buf_q    <= dividend_buf_d;
            divisor_buf_q     <= divisor_buf_d;
            rem_q             <= rem_d;
            quo_q             <= quo_d;
            div_mag_q         <= div_mag_d;
            dividend_orig_q   <= dividend_orig_d;
            neg_quot_q        <= neg_quot_d;
            neg_rem_q         <= neg_rem_d;
            div_zero_q        <= div_zero_d;
            count_q           <= count_d;
            dividend_tready_q <= dividend_tready_d;
            divisor_tready_q  <= divisor_tready_d;
            dout_tvalid_q     <= dout_tvalid_d;
            dout_tdata_q      <= dout_tdata_d;
            dout_tuser_q      <= dout_tuser_d;
        end
    end

    assign s_axis_dividend_tready = dividend_tready_q;
    assign s_axis_divisor_tready  = divisor_tready_q;
    assign m_axis_dout_tvalid     = dout_tvalid_q;
    assign m_axis_dout_tdata      = dout_tdata_q;
    assign m_axis_dout_tuser      = dout_tuser_q;

endmodule

// File: tb/tb_axis_seq_divider.sv
// tb_axis_seq_divider: directed vectors applied to a signed and an unsigned
// instance sharing the same input channels, plus hand-written sequences for
// staggered operands, output backpressure and asynchronous reset.

module tb_axis_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dvd_valid;
    logic [31:0] dvd_data;
    logic        dvs_valid;
    logic [31:0] dvs_data;
    logic        m_ready;

    logic        s_dvd_ready, s_dvs_ready, s_valid, s_user;
    logic [63:0] s_data;
    logic        u_dvd_ready, u_dvs_ready, u_valid, u_user;
    logic [63:0] u_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] s_exp;
        logic        s_user_exp;
        logic [63:0] u_exp;
        logic        u_user_exp;
    } vec_t;

    vec_t vecs [10];

    axis_seq_divider #(.WIDTH(32), .SIGNED(1'b1)) dut_signed (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (s_dvd_ready),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (s_dvs_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (s_valid),
        .m_axis_dout_tready     (m_ready),
        .m_axis_dout_tdata      (s_data),
        .m_axis_dout_tuser      (s_user)
    );

    axis_seq_divider #(.WIDTH(32), .SIGNED(1'b0)) dut_unsigned (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (u_dvd_ready),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (u_dvs_ready),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (u_valid),
        .m_axis_dout_tready     (m_ready),
        .m_axis_dout_tdata      (u_data),
        .m_axis_dout_tuser      (u_user)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Present both operands for one cycle; returns in the first CALC cycle.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b);
        check({name, " readies idle"}, 64'({s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}), 64'hF);
        dvd_valid = 1'b1;
        dvd_data  = a;
        dvs_valid = 1'b1;
        dvs_data  = b;
        @(negedge clk);
        dvd_valid = 1'b0;
        dvs_valid = 1'b0;
        check({name, " readies busy"}, 64'({s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}), 64'h0);
    endtask

    // Wait for the result, check latency and data, then the return to idle.
    task automatic checkOutput(input string name, input vec_t v, input int start_cyc, input int exp_cyc);
        int cyc;
        cyc = start_cyc;
        while (s_valid !== 1'b1 && cyc < start_cyc + 200) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(exp_cyc));
        check({name, " unsigned valid"}, 64'(u_valid), 64'd1);
        check({name, " signed data"}, s_data, v.s_exp);
        check({name, " signed user"}, 64'(s_user), 64'(v.s_user_exp));
        check({name, " unsigned data"}, u_data, v.u_exp);
        check({name, " unsigned user"}, 64'(u_user), 64'(v.u_user_exp));
        if (m_ready) begin
            @(negedge clk);
            check({name, " after handshake"},
                  64'({s_valid, u_valid, s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}),
                  64'b001111);
        end
    endtask

    initial begin
        int seen;
        vec_t v;

        dvd_valid = 1'b0;
        dvd_data  = '0;
        dvs_valid = 1'b0;
        dvs_data  = '0;
        m_ready   = 1'b1;

        vecs[0] = '{32'd100,       32'd7,         64'h0000000E_00000002, 1'b0, 64'h0000000E_00000002, 1'b0};
        vecs[1] = '{32'hFFFFFFF9,  32'd2,         64'hFFFFFFFD_FFFFFFFF, 1'b0, 64'h7FFFFFFC_00000001, 1'b0};
        vecs[2] = '{32'd7,         32'hFFFFFFFE,  64'hFFFFFFFD_00000001, 1'b0, 64'h00000000_00000007, 1'b0};
        vecs[3] = '{32'd5,         32'd0,         64'hFFFFFFFF_00000005, 1'b1, 64'hFFFFFFFF_00000005, 1'b1};
        vecs[4] = '{32'h80000000,  32'hFFFFFFFF,  64'h80000000_00000000, 1'b0, 64'h00000000_80000000, 1'b0};
        vecs[5] = '{32'hFFFFFF9C,  32'd7,         64'hFFFFFFF2_FFFFFFFE, 1'b0, 64'h24924916_00000002, 1'b0};
        vecs[6] = '{32'hFFFFFF9C,  32'hFFFFFFF9,  64'h0000000E_FFFFFFFE, 1'b0, 64'h00000000_FFFFFF9C, 1'b0};
        vecs[7] = '{32'hFFFFFFFB,  32'd0,         64'hFFFFFFFF_FFFFFFFB, 1'b1, 64'hFFFFFFFF_FFFFFFFB, 1'b1};
        vecs[8] = '{32'd0,         32'd5,         64'h00000000_00000000, 1'b0, 64'h00000000_00000000, 1'b0};
        vecs[9] = '{32'h80000000,  32'd1,         64'h80000000_00000000, 1'b0, 64'h80000000_00000000, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset valid/user", 64'({s_valid, s_user, u_valid, u_user}), 64'h0);
        check("reset signed data", s_data, 64'h0);
        check("reset unsigned data", u_data, 64'h0);
        check("reset readies", 64'({s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}), 64'hF);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors, operands together in cycle 0
        for (int i = 0; i < 10; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b);
            checkOutput($sformatf("vec%0d", i), vecs[i], 1, 33);
        end

        // Staggered arrival: dividend in cycle 0, divisor in cycle 5; the
        // dividend initiator keeps tvalid high with new data that must not be taken
        dvd_valid = 1'b1;
        dvd_data  = 32'd100;
        @(negedge clk);
        check("stagger dividend ready low", 64'({s_dvd_ready, u_dvd_ready}), 64'h0);
        check("stagger divisor ready high", 64'({s_dvs_ready, u_dvs_ready}), 64'h3);
        dvd_data = 32'd55;
        repeat (4) @(negedge clk);
        check("stagger divisor ready cycle5", 64'({s_dvs_ready, u_dvs_ready}), 64'h3);
        dvs_valid = 1'b1;
        dvs_data  = 32'd7;
        @(negedge clk);
        dvs_valid = 1'b0;
        dvd_valid = 1'b0;
        checkOutput("stagger", vecs[0], 6, 38);

        // Backpressure: result held stable while the consumer stalls
        m_ready = 1'b0;
        applyStimulus("bp", 32'hFFFFFFF9, 32'd2);
        checkOutput("bp", vecs[1], 1, 33);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp stall%0d valid/ready", k),
                  64'({s_valid, u_valid, s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}),
                  64'b110000);
            check($sformatf("bp stall%0d data", k), s_data, 64'hFFFFFFFD_FFFFFFFF);
            check($sformatf("bp stall%0d user", k), 64'({s_user, u_user}), 64'h0);
        end
        m_ready = 1'b1;
        @(negedge clk);
        check("bp release", 64'({s_valid, u_valid, s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}),
              64'b001111);

        // Reset while a result waits in DONE: outputs clear without a clock edge
        m_ready = 1'b0;
        applyStimulus("rstdone", 32'd5, 32'd0);
        checkOutput("rstdone", vecs[3], 1, 33);
        rst_n = 1'b0;
        #1;
        check("rstdone async clear", 64'({s_valid, s_user, u_valid, u_user}), 64'h0);
        check("rstdone data clear", s_data, 64'h0);
        check("rstdone readies", 64'({s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}), 64'hF);
        @(negedge clk);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        @(negedge clk);

        // Reset in the middle of CALC: operation discarded, then a fresh divide
        applyStimulus("rstcalc", 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstcalc async", 64'({s_valid, u_valid, s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}),
              64'b001111);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstcalc readies", 64'({s_dvd_ready, s_dvs_ready, u_dvd_ready, u_dvs_ready}), 64'hF);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (s_valid || u_valid) seen = 1;
        end
        check("rstcalc no stale result", 64'(seen), 64'd0);
        v = '{32'd9, 32'd3, 64'h00000003_00000000, 1'b0, 64'h00000003_00000000, 1'b0};
        applyStimulus("fresh", v.a, v.b);
        checkOutput("fresh", v, 1, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
